// File: rtl/serial_add_seq.sv
// serial_add_seq
//   Bit-serial add sequencer wrapped around one external single-bit full-adder
//   cell. It loads two WIDTH-bit operands and feeds one bit pair plus the
//   registered carry to the cell each clock, LSB first. It collects the cell's
//   sum and carry-out and builds the WIDTH-bit result. One addition takes
//   WIDTH cycles in RUN, then one cycle in DONE.
//
// Optional build macro: SERIAL_SUB_EN
//   Adds the `sub` input. When sub=1 the block computes op_a - op_b. It does
//   this by inverting the B bit and forcing the initial carry to 1, so
//   cout=1 means "no borrow".
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin an operation (sampled only in IDLE)
//   op_a     in   [WIDTH] operand A, captured on the accepted start edge
//   op_b     in   [WIDTH] operand B, captured on the accepted start edge
//   cin      in   initial carry, captured on the accepted start edge
//   sub      in   (SERIAL_SUB_EN only) subtract select, captured with operands
//   busy     out  high while bits are being processed
//   done     out  one-cycle pulse; result/cout valid
//   result   out  [WIDTH] sum, held until the next accepted start
//   cout     out  final carry-out, held until the next accepted start
//   fa_a     out  bit to full-adder input a
//   fa_b     out  bit to full-adder input b
//   fa_c     out  carry to full-adder input c
//   fa_sum   in   sum returned by the full adder
//   fa_cout  in   carry-out returned by the full adder
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_bit;
  logic             b_inv;
  logic             carry_init;

`ifdef SERIAL_SUB_EN
  logic sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (accept) begin
      sub_q <= sub;
    end
  end

  // Subtraction is A + ~B + 1: invert the B stream and seed the carry with 1.
  assign b_inv      = sub_q;
  assign carry_init = sub ? 1'b1 : cin;
`else
  assign b_inv      = 1'b0;
  assign carry_init = cin;
`endif

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand shifters, carry, bit counter and result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sh    <= op_a;
      b_sh    <= op_b;
      carry_q <= carry_init;
      cnt     <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else if (state_q == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      // The sum arrives LSB first, so it enters at the MSB. After WIDTH
      // shifts, bit 0 has reached position 0.
      result  <= {fa_sum, result[WIDTH-1:1]};
      carry_q <= fa_cout;
      if (last_bit) begin
        cout <= fa_cout;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The full-adder drive comes from registers only. This keeps start and the
  // operand inputs out of the combinational loop through the cell.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    fa_a = 1'b0;
    fa_b = 1'b0;
    fa_c = 1'b0;
    if (state_q == RUN) begin
      fa_a = a_sh[0];
      fa_b = b_sh[0] ^ b_inv;
      fa_c = carry_q;
    end
  end

endmodule
